camera_pixel_capture: RTL and testbench

- Producer end of the pixel stream that feeds the image processor.
- Samples the OV7670 parallel bus (RGB565, two bytes per pixel) and packs each pixel into 8-bit RGB332.
- Generates frame-buffer write coordinates and a write strobe; the frame buffer and the image processor read the stored/streamed pixels downstream.
- Also flags frame boundaries so downstream per-frame counters can reset cleanly.

---
 rtl/camera_pixel_capture_if.sv | 24 ++
 rtl/camera_pixel_capture.sv | 133 +++++++++++++
 tb/tb_camera_pixel_capture.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/camera_pixel_capture_if.sv
// Pixel-capture bus: OV7670 parallel input on one side, frame-buffer write port on the other.
interface camera_pixel_capture_if;
    logic [7:0] CAM_DATA;
    logic       CAM_HREF;
    logic       CAM_VSYNC;
    logic [7:0] PIXEL_OUT;
    logic [9:0] WRITE_X;
    logic [9:0] WRITE_Y;
    logic       WRITE_EN;
    logic       FRAME_DONE;
    logic [9:0] LINE_COUNT;

    // Capture block: samples the camera, drives the frame-buffer write port.
    modport master (
        input  CAM_DATA, CAM_HREF, CAM_VSYNC,
        output PIXEL_OUT, WRITE_X, WRITE_Y, WRITE_EN, FRAME_DONE, LINE_COUNT
    );

    // Camera model / frame-buffer side.
    modport slave (
        output CAM_DATA, CAM_HREF, CAM_VSYNC,
        input  PIXEL_OUT, WRITE_X, WRITE_Y, WRITE_EN, FRAME_DONE, LINE_COUNT
    );
endinterface

// File: rtl/camera_pixel_capture.sv
// OV7670 RGB565 capture: packs two-byte pixels into RGB332 and issues frame-buffer writes.
module camera_pixel_capture #(
    parameter int unsigned SCREEN_WIDTH    = 176,
    parameter int unsigned SCREEN_HEIGHT   = 144,
    parameter bit          HIGH_BYTE_FIRST = 1'b1
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    camera_pixel_capture_if.master        bus
);

    localparam logic [9:0] XLim = 10'(SCREEN_WIDTH);
    localparam logic [9:0] YLim = 10'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {StSync, StBlank, StActive, StDone} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       r_phase;
    logic [7:0] r_byte_a;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [7:0] r_pixel;
    logic [9:0] r_wx;
    logic [9:0] r_wy;
    logic       r_wen;
    logic [9:0] r_line_count;
    logic       w_frame_done;

    logic       w_line_end;
    logic [9:0] w_y_line;
    logic [7:0] w_hi;
    logic [7:0] w_lo;
    logic [7:0] w_pixel;
    logic       w_in_frame;

    // A line closes on HREF low or on a VSYNC abort; only lines that saw bytes bump y.
    assign w_line_end = (r_state == StActive) && (!bus.CAM_HREF || bus.CAM_VSYNC);
    assign w_y_line   = (w_line_end && (r_x != 10'd0) && (r_y < YLim)) ? r_y + 10'd1 : r_y;
    assign w_hi       = HIGH_BYTE_FIRST ? r_byte_a : bus.CAM_DATA;
    assign w_lo       = HIGH_BYTE_FIRST ? bus.CAM_DATA : r_byte_a;
    assign w_pixel    = {w_hi[7:5], w_hi[2:0], w_lo[4:3]};
    assign w_in_frame = (r_x < XLim) && (r_y < YLim);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= StSync;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: SYNC waits for VSYNC, BLANK for its fall, ACTIVE until VSYNC rises.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StSync:   if (bus.CAM_VSYNC)  w_state_next = StBlank;
            StBlank:  if (!bus.CAM_VSYNC) w_state_next = StActive;
            StActive: if (bus.CAM_VSYNC)  w_state_next = StDone;
            StDone:   w_state_next = StBlank;
            default:  w_state_next = StSync;
        endcase
    end

    // Output decode: frame-done pulse is the single DONE cycle.
    always_comb begin
        w_frame_done = 1'b0;
        if (r_state == StDone) begin
            w_frame_done = 1'b1;
        end
    end

    // Byte pairing, x/y counters and registered write port.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_phase      <= 1'b0;
            r_byte_a     <= 8'd0;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_pixel      <= 8'd0;
            r_wx         <= 10'd0;
            r_wy         <= 10'd0;
            r_wen        <= 1'b0;
            r_line_count <= 10'd0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                StBlank: begin
                    if (!bus.CAM_VSYNC) begin
                        r_x     <= 10'd0;
                        r_y     <= 10'd0;
                        r_phase <= 1'b0;
                    end
                end
                StActive: begin
                    if (w_line_end) begin
                        // Also drops a half-received pixel.
                        r_y     <= w_y_line;
                        r_x     <= 10'd0;
                        r_phase <= 1'b0;
                    end else if (!r_phase) begin
                        r_byte_a <= bus.CAM_DATA;
                        r_phase  <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (w_in_frame) begin
                            r_pixel <= w_pixel;
                            r_wx    <= r_x;
                            r_wy    <= r_y;
                            r_wen   <= 1'b1;
                        end
                        if (r_x != 10'h3FF) begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                    if (bus.CAM_VSYNC) begin
                        r_line_count <= (w_y_line > YLim) ? YLim : w_y_line;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PIXEL_OUT  = r_pixel;
    assign bus.WRITE_X    = r_wx;
    assign bus.WRITE_Y    = r_wy;
    assign bus.WRITE_EN   = r_wen;
    assign bus.FRAME_DONE = w_frame_done;
    assign bus.LINE_COUNT = r_line_count;

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed bench: three capture instances (default, byte-swapped, small screen) share one camera.
module tb_camera_pixel_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cam_data;
    logic       cam_href;
    logic       cam_vsync;
    logic [7:0] exp_pix;

    always #5 clk = ~clk;

    camera_pixel_capture_if u_if_def ();
    camera_pixel_capture_if u_if_swp ();
    camera_pixel_capture_if u_if_sml ();

    assign u_if_def.CAM_DATA  = cam_data;
    assign u_if_def.CAM_HREF  = cam_href;
    assign u_if_def.CAM_VSYNC = cam_vsync;
    assign u_if_swp.CAM_DATA  = cam_data;
    assign u_if_swp.CAM_HREF  = cam_href;
    assign u_if_swp.CAM_VSYNC = cam_vsync;
    assign u_if_sml.CAM_DATA  = cam_data;
    assign u_if_sml.CAM_HREF  = cam_href;
    assign u_if_sml.CAM_VSYNC = cam_vsync;

    camera_pixel_capture u_dut_def (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (u_if_def.master)
    );

    camera_pixel_capture #(
        .HIGH_BYTE_FIRST (1'b0)
    ) u_dut_swp (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (u_if_swp.master)
    );

    camera_pixel_capture #(
        .SCREEN_WIDTH  (8),
        .SCREEN_HEIGHT (6)
    ) u_dut_sml (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (u_if_sml.master)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Strobe monitors: cumulative counts, last coordinates, pixels differing from exp_pix.
    int unsigned def_cnt = 0, def_bad = 0, def_fd = 0, def_lx = 0, def_ly = 0;
    int unsigned sml_cnt = 0, sml_bad = 0, sml_fd = 0, sml_lx = 0, sml_ly = 0;

    always @(negedge clk) begin
        if (u_if_def.WRITE_EN) begin
            def_cnt <= def_cnt + 1;
            def_lx  <= int'(u_if_def.WRITE_X);
            def_ly  <= int'(u_if_def.WRITE_Y);
            if (u_if_def.PIXEL_OUT !== exp_pix) def_bad <= def_bad + 1;
        end
        if (u_if_def.FRAME_DONE) def_fd <= def_fd + 1;
        if (u_if_sml.WRITE_EN) begin
            sml_cnt <= sml_cnt + 1;
            sml_lx  <= int'(u_if_sml.WRITE_X);
            sml_ly  <= int'(u_if_sml.WRITE_Y);
            if (u_if_sml.PIXEL_OUT !== exp_pix) sml_bad <= sml_bad + 1;
        end
        if (u_if_sml.FRAME_DONE) sml_fd <= sml_fd + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Apply inputs, let one rising edge sample them, return just after the next falling edge.
    task automatic drive(input logic [7:0] d, input logic h, input logic v);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        @(negedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1);
        drive(b0, 1'b1, 1'b0);
        drive(b1, 1'b1, 1'b0);
    endtask

    task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < npix; i++) send_pixel(b0, b1);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
    endtask

    int unsigned c0, b0, f0;

    initial begin
        rst_n     = 1'b0;
        cam_data  = 8'h00;
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        exp_pix   = 8'h1C;
        @(negedge clk);
        #1;
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        check_val("rst_wen",   u_if_def.WRITE_EN,   0);
        check_val("rst_pixel", u_if_def.PIXEL_OUT,  0);
        check_val("rst_x",     u_if_def.WRITE_X,    0);
        check_val("rst_y",     u_if_def.WRITE_Y,    0);
        check_val("rst_fd",    u_if_def.FRAME_DONE, 0);
        check_val("rst_lc",    u_if_def.LINE_COUNT, 0);

        rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0);

        // Single pixel 0xF8,0x1F -> 0xE3 (swapped instance sees hi=0x1F -> 0x1F).
        drive(8'hF8, 1'b1, 1'b0);
        check_val("lat_before_b", u_if_def.WRITE_EN, 0);
        drive(8'h1F, 1'b1, 1'b0);
        check_val("px1_wen",   u_if_def.WRITE_EN,  1);
        check_val("px1_pixel", u_if_def.PIXEL_OUT, 8'hE3);
        check_val("px1_x",     u_if_def.WRITE_X,   0);
        check_val("px1_y",     u_if_def.WRITE_Y,   0);
        check_val("px1_swp",   u_if_swp.PIXEL_OUT, 8'h1F);
        drive(8'h00, 1'b0, 1'b0);
        check_val("strobe_width", u_if_def.WRITE_EN, 0);

        // Swapped byte order: 0x1F,0xF8.
        drive(8'h1F, 1'b1, 1'b0);
        drive(8'hF8, 1'b1, 1'b0);
        check_val("swp_pixel",   u_if_swp.PIXEL_OUT, 8'hE3);
        check_val("unswp_pixel", u_if_def.PIXEL_OUT, 8'h1F);
        check_val("line2_y",     u_if_def.WRITE_Y,   1);
        drive(8'h00, 1'b0, 1'b0);

        // Odd line: five bytes, trailing byte dropped.
        c0 = def_cnt;
        drive(8'hF8, 1'b1, 1'b0);
        drive(8'h1F, 1'b1, 1'b0);
        drive(8'hF8, 1'b1, 1'b0);
        drive(8'h1F, 1'b1, 1'b0);
        drive(8'hAA, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check_val("odd_cnt",    def_cnt - c0, 2);
        check_val("odd_last_x", def_lx, 1);
        check_val("odd_last_y", def_ly, 2);
        send_pixel(8'hF8, 8'h1F);
        check_val("after_odd_x", u_if_def.WRITE_X, 0);
        check_val("after_odd_y", u_if_def.WRITE_Y, 3);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        check_val("f1_fd", u_if_def.FRAME_DONE, 1);
        check_val("f1_lc", u_if_def.LINE_COUNT, 4);
        drive(8'h00, 1'b0, 1'b1);
        check_val("f1_fd_pulse", u_if_def.FRAME_DONE, 0);

        // Abort: two full lines, three pixels plus a half pixel, then VSYNC with HREF high.
        drive(8'h00, 1'b0, 1'b0);
        c0 = def_cnt;
        send_line(4, 8'h07, 8'hE0);
        send_line(4, 8'h07, 8'hE0);
        for (int i = 0; i < 3; i++) send_pixel(8'h07, 8'hE0);
        drive(8'h07, 1'b1, 1'b0);
        drive(8'hE0, 1'b1, 1'b1);
        check_val("abort_fd",  u_if_def.FRAME_DONE, 1);
        check_val("abort_lc",  u_if_def.LINE_COUNT, 3);
        check_val("abort_wen", u_if_def.WRITE_EN,   0);
        check_val("abort_cnt", def_cnt - c0, 11);

        // Reset in the middle of a line.
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        send_pixel(8'hF8, 8'h1F);
        drive(8'hF8, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(8'h1F, 1'b1, 1'b0);
        check_val("mrst_wen",   u_if_def.WRITE_EN,   0);
        check_val("mrst_pixel", u_if_def.PIXEL_OUT,  0);
        check_val("mrst_x",     u_if_def.WRITE_X,    0);
        check_val("mrst_y",     u_if_def.WRITE_Y,    0);
        check_val("mrst_lc",    u_if_def.LINE_COUNT, 0);
        rst_n = 1'b1;
        c0 = def_cnt;
        repeat (6) drive(8'hF8, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        repeat (6) drive(8'hF8, 1'b1, 1'b1);
        check_val("no_strobe_sync_blank", def_cnt - c0, 0);

        // Full 176x144 green frame.
        drive(8'h00, 1'b0, 1'b0);
        c0 = def_cnt;
        b0 = def_bad;
        f0 = def_fd;
        for (int l = 0; l < 144; l++) send_line(176, 8'h07, 8'hE0);
        drive(8'h00, 1'b0, 1'b1);
        check_val("full_fd", u_if_def.FRAME_DONE, 1);
        check_val("full_lc", u_if_def.LINE_COUNT, 144);
        drive(8'h00, 1'b0, 1'b1);
        check_val("full_cnt",    def_cnt - c0, 25344);
        check_val("full_bad",    def_bad - b0, 0);
        check_val("full_last_x", def_lx, 175);
        check_val("full_last_y", def_ly, 143);
        check_val("full_fd_cnt", def_fd - f0, 1);

        // Oversize frame on the 8x6 instance: 8 lines of 10 pixels.
        drive(8'h00, 1'b0, 1'b0);
        c0 = sml_cnt;
        b0 = sml_bad;
        f0 = sml_fd;
        for (int l = 0; l < 8; l++) send_line(10, 8'h07, 8'hE0);
        drive(8'h00, 1'b0, 1'b1);
        check_val("ovr_lc",     u_if_sml.LINE_COUNT, 6);
        check_val("ovr_def_lc", u_if_def.LINE_COUNT, 8);
        drive(8'h00, 1'b0, 1'b1);
        check_val("ovr_cnt",    sml_cnt - c0, 48);
        check_val("ovr_bad",    sml_bad - b0, 0);
        check_val("ovr_last_x", sml_lx, 7);
        check_val("ovr_last_y", sml_ly, 5);
        check_val("ovr_fd_cnt", sml_fd - f0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
